// File: rtl/ifu_fetch_ctrl.sv
// Multi-cycle RV32 instruction fetch controller: one outstanding memory request,
// redirect-aware stale-response dropping. Optional counters under IFU_FETCH_PERF_EN.
module ifu_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [31:0] req_addr,
    input  logic        resp_valid,
    output logic        resp_ready,
    input  logic [31:0] resp_data,
    input  logic        resp_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_fault,
`ifdef IFU_FETCH_PERF_EN
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt,
`endif
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic        r_fault;

    logic        w_aligned;
    logic        w_req_fire;
    logic        w_out_fire;

    // Handshakes: a transfer happens on a channel only in a cycle where both
    // valid and ready are high at the rising edge; valid never depends on ready.
    assign w_aligned  = (r_pc[1:0] == 2'b00);
    assign w_req_fire = req_valid && req_ready;
    assign w_out_fire = out_valid && out_ready;

    assign req_valid   = (r_state == S_REQ) && w_aligned;
    assign req_addr    = r_pc;
    assign resp_ready  = (r_state == S_WAIT) || (r_state == S_DROP);
    assign out_valid   = (r_state == S_OUT) && !redirect_valid;
    assign out_pc      = r_pc;
    assign out_inst    = r_inst;
    assign out_fault   = r_fault;
    assign o_dbg_state = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_REQ;
            r_pc    <= RESET_PC;
            r_inst  <= NOP_INST;
            r_fault <= 1'b0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (redirect_valid) begin
                        r_pc <= redirect_pc;
                        // An already-accepted request still owes us a response.
                        if (w_req_fire) r_state <= S_DROP;
                    end else if (!w_aligned) begin
                        r_inst  <= NOP_INST;
                        r_fault <= 1'b1;
                        r_state <= S_OUT;
                    end else if (req_ready) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (redirect_valid) begin
                        r_pc    <= redirect_pc;
                        r_state <= resp_valid ? S_REQ : S_DROP;
                    end else if (resp_valid) begin
                        r_inst  <= resp_err ? NOP_INST : resp_data;
                        r_fault <= resp_err;
                        r_state <= S_OUT;
                    end
                end
                S_DROP: begin
                    if (redirect_valid) begin
                        r_pc <= redirect_pc;
                    end else if (resp_valid) begin
                        r_state <= S_REQ;
                    end
                end
                S_OUT: begin
                    if (redirect_valid) begin
                        r_pc    <= redirect_pc;
                        r_fault <= 1'b0;
                        r_state <= S_REQ;
                    end else if (out_ready) begin
                        r_pc    <= r_pc + 32'd4;
                        r_fault <= 1'b0;
                        r_state <= S_REQ;
                    end
                end
                default: r_state <= S_REQ;
            endcase
        end
    end

`ifdef IFU_FETCH_PERF_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_cnt <= 32'd0;
            r_stall_cnt <= 32'd0;
        end else begin
            if (w_out_fire) r_fetch_cnt <= r_fetch_cnt + 32'd1;
            if (resp_ready) r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign perf_fetch_cnt = r_fetch_cnt;
    assign perf_stall_cnt = r_stall_cnt;

    task automatic GetFetchPerf(output int unsigned fetch_cnt, output int unsigned stall_cnt);
        fetch_cnt = r_fetch_cnt;
        stall_cnt = r_stall_cnt;
    endtask
`else
    logic w_unused_fire;
    assign w_unused_fire = w_out_fire;
`endif

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed bench for ifu_fetch_ctrl: latency, stall, redirects, faults, pc wrap.
module tb_ifu_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_fault;
    logic [1:0]  dbg_state;
`ifdef IFU_FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int check_cnt;
    int pass_cnt;

    ifu_fetch_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst), .out_fault(out_fault),
`ifdef IFU_FETCH_PERF_EN
        .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt),
`endif
        .o_dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        req_ready = 1'b0; resp_valid = 1'b0; resp_data = 32'h0;
        resp_err = 1'b0; out_ready = 1'b0;
        repeat (3) tick();
        check_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_in_out_valid: got %b want 0", out_valid); else pass_cnt++;
        rst_n = 1'b1;
        #1;
        check_cnt++; if (req_valid !== 1'b1) $display("FAIL rst_req_valid: got %b want 1", req_valid); else pass_cnt++;
        check_cnt++; if (req_addr !== 32'h8000_0000) $display("FAIL rst_req_addr: got %h want 80000000", req_addr); else pass_cnt++;
        check_cnt++; if (resp_ready !== 1'b0) $display("FAIL rst_resp_ready: got %b want 0", resp_ready); else pass_cnt++;
        check_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else pass_cnt++;
        check_cnt++; if (out_pc !== 32'h8000_0000) $display("FAIL rst_out_pc: got %h want 80000000", out_pc); else pass_cnt++;
        check_cnt++; if (out_inst !== 32'h0000_0013) $display("FAIL rst_out_inst: got %h want 00000013", out_inst); else pass_cnt++;
        check_cnt++; if (out_fault !== 1'b0) $display("FAIL rst_out_fault: got %b want 0", out_fault); else pass_cnt++;
    endtask

    // Fetch from S_REQ with a one-cycle memory, leaving the DUT in S_OUT.
    task automatic fetch_one(input logic [31:0] data, input logic err);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0; resp_valid = 1'b1; resp_data = data; resp_err = err;
        tick();
        resp_valid = 1'b0; resp_err = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_latency();
        req_ready = 1'b1;
        check_cnt++; if (req_valid !== 1'b1 || req_addr !== 32'h8000_0000) $display("FAIL lat_c0_req: got %b/%h want 1/80000000", req_valid, req_addr); else pass_cnt++;
        tick();
        req_ready = 1'b0; resp_valid = 1'b1; resp_data = 32'h0000_0413;
        check_cnt++; if (resp_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL lat_c1: got resp_ready=%b out_valid=%b want 1/0", resp_ready, out_valid); else pass_cnt++;
        tick();
        resp_valid = 1'b0; out_ready = 1'b1;
        check_cnt++; if (out_valid !== 1'b1) $display("FAIL lat_c2_out_valid: got %b want 1", out_valid); else pass_cnt++;
        check_cnt++; if (out_pc !== 32'h8000_0000 || out_inst !== 32'h0000_0413) $display("FAIL lat_c2_data: got %h/%h want 80000000/00000413", out_pc, out_inst); else pass_cnt++;
        check_cnt++; if (out_fault !== 1'b0) $display("FAIL lat_c2_fault: got %b want 0", out_fault); else pass_cnt++;
        tick();
        out_ready = 1'b0;
        check_cnt++; if (req_valid !== 1'b1 || req_addr !== 32'h8000_0004) $display("FAIL lat_c3_req: got %b/%h want 1/80000004", req_valid, req_addr); else pass_cnt++;
    endtask

    task automatic test_stall();
        fetch_one(32'h0000_0513, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check_cnt++;
            if (out_valid !== 1'b1 || out_pc !== 32'h8000_0004 || out_inst !== 32'h0000_0513 || req_valid !== 1'b0)
                $display("FAIL stall_hold_%0d: got v=%b pc=%h inst=%h req=%b want 1/80000004/00000513/0", i, out_valid, out_pc, out_inst, req_valid);
            else pass_cnt++;
            tick();
        end
        consume();
        check_cnt++; if (req_valid !== 1'b1 || req_addr !== 32'h8000_0008) $display("FAIL stall_next_req: got %b/%h want 1/80000008", req_valid, req_addr); else pass_cnt++;
    endtask

    task automatic test_resp_err();
        fetch_one(32'h1234_5678, 1'b1);
        check_cnt++; if (out_valid !== 1'b1 || out_fault !== 1'b1 || out_inst !== 32'h0000_0013 || out_pc !== 32'h8000_0008)
            $display("FAIL err_out: got v=%b f=%b inst=%h pc=%h want 1/1/00000013/80000008", out_valid, out_fault, out_inst, out_pc); else pass_cnt++;
        consume();
        check_cnt++; if (req_valid !== 1'b1 || req_addr !== 32'h8000_000C || out_fault !== 1'b0)
            $display("FAIL err_next: got req=%b addr=%h f=%b want 1/8000000C/0", req_valid, req_addr, out_fault); else pass_cnt++;
    endtask

    task automatic test_redirect_drop();
        req_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
        tick();
        req_ready = 1'b0; redirect_valid = 1'b0;
        check_cnt++; if (resp_ready !== 1'b1 || req_valid !== 1'b0) $display("FAIL drop_enter: got resp_ready=%b req=%b want 1/0", resp_ready, req_valid); else pass_cnt++;
        for (int i = 0; i < 2; i++) begin
            check_cnt++; if (out_valid !== 1'b0 || req_valid !== 1'b0) $display("FAIL drop_wait_%0d: got v=%b req=%b want 0/0", i, out_valid, req_valid); else pass_cnt++;
            tick();
        end
        resp_valid = 1'b1; resp_data = 32'hDEAD_BEEF;
        tick();
        resp_valid = 1'b0;
        check_cnt++; if (out_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== 32'h8000_0100)
            $display("FAIL drop_next_req: got v=%b req=%b addr=%h want 0/1/80000100", out_valid, req_valid, req_addr); else pass_cnt++;
        fetch_one(32'h0000_0613, 1'b0);
        check_cnt++; if (out_valid !== 1'b1 || out_inst !== 32'h0000_0613 || out_pc !== 32'h8000_0100)
            $display("FAIL drop_after_inst: got v=%b inst=%h pc=%h want 1/00000613/80000100", out_valid, out_inst, out_pc); else pass_cnt++;
        consume();
    endtask

    task automatic test_wait_redirect();
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
        resp_valid = 1'b1; resp_data = 32'hBAD0_BAD0;
        tick();
        redirect_valid = 1'b0; resp_valid = 1'b0;
        check_cnt++; if (req_valid !== 1'b1 || req_addr !== 32'h8000_0200 || out_valid !== 1'b0)
            $display("FAIL wait_redir_resp: got req=%b addr=%h v=%b want 1/80000200/0", req_valid, req_addr, out_valid); else pass_cnt++;
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h8000_0300;
        tick();
        redirect_valid = 1'b0;
        check_cnt++; if (req_valid !== 1'b0 || resp_ready !== 1'b1) $display("FAIL wait_redir_drop: got req=%b resp_ready=%b want 0/1", req_valid, resp_ready); else pass_cnt++;
        resp_valid = 1'b1; resp_data = 32'hBAD1_BAD1;
        tick();
        resp_valid = 1'b0;
        check_cnt++; if (req_valid !== 1'b1 || req_addr !== 32'h8000_0300 || out_valid !== 1'b0)
            $display("FAIL wait_redir_drop_next: got req=%b addr=%h v=%b want 1/80000300/0", req_valid, req_addr, out_valid); else pass_cnt++;
    endtask

    task automatic test_misaligned();
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0102;
        tick();
        redirect_valid = 1'b0;
        check_cnt++; if (req_valid !== 1'b0) $display("FAIL mis_req_valid: got %b want 0", req_valid); else pass_cnt++;
        tick();
        check_cnt++; if (out_valid !== 1'b1 || out_pc !== 32'h8000_0102 || out_fault !== 1'b1 || out_inst !== 32'h0000_0013 || req_valid !== 1'b0)
            $display("FAIL mis_out: got v=%b pc=%h f=%b inst=%h req=%b want 1/80000102/1/00000013/0", out_valid, out_pc, out_fault, out_inst, req_valid); else pass_cnt++;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; out_ready = 1'b1;
        #1;
        check_cnt++; if (out_valid !== 1'b0) $display("FAIL mis_redir_mask: got %b want 0", out_valid); else pass_cnt++;
        tick();
        redirect_valid = 1'b0; out_ready = 1'b0;
        check_cnt++; if (req_valid !== 1'b1 || req_addr !== 32'hFFFF_FFFC || out_fault !== 1'b0)
            $display("FAIL mis_redir_req: got req=%b addr=%h f=%b want 1/FFFFFFFC/0", req_valid, req_addr, out_fault); else pass_cnt++;
    endtask

    task automatic test_wrap();
`ifdef IFU_FETCH_PERF_EN
        logic [31:0] fetch_before;
`endif
        fetch_one(32'h0000_0713, 1'b0);
        check_cnt++; if (out_valid !== 1'b1 || out_pc !== 32'hFFFF_FFFC || out_inst !== 32'h0000_0713)
            $display("FAIL wrap_out: got v=%b pc=%h inst=%h want 1/FFFFFFFC/00000713", out_valid, out_pc, out_inst); else pass_cnt++;
`ifdef IFU_FETCH_PERF_EN
        fetch_before = perf_fetch_cnt;
`endif
        consume();
        check_cnt++; if (req_valid !== 1'b1 || req_addr !== 32'h0000_0000) $display("FAIL wrap_next_req: got %b/%h want 1/00000000", req_valid, req_addr); else pass_cnt++;
`ifdef IFU_FETCH_PERF_EN
        check_cnt++; if (perf_fetch_cnt !== fetch_before + 32'd1) $display("FAIL perf_fetch_inc: got %h want %h", perf_fetch_cnt, fetch_before + 32'd1); else pass_cnt++;
`endif
    endtask

    initial begin
        check_cnt = 0;
        pass_cnt  = 0;
        test_reset();
        test_latency();
        test_stall();
        test_resp_err();
        test_redirect_drop();
        test_wait_redirect();
        test_misaligned();
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
